// File: rtl/sample_merge.sv
// Merges low/high byte pairs into signed 16-bit samples and queues them for the FIR.
// Sample visible one cycle after its high byte; no input backpressure, drops on full FIFO or high-byte timeout.
module sample_merge #(
    parameter int WIDTH   = 16,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [7:0]               byte_i,
    input  logic                     byte_valid_i,
    input  logic                     resync_i,
    input  logic                     start_i,
    output logic signed [WIDTH-1:0]  data_o,
    output logic                     merge_finished_o,
    output logic [$clog2(DEPTH):0]   fill_o,
    output logic                     overflow_o,
    output logic                     underrun_o,
    output logic                     timeout_o,
    output logic [7:0]               drop_cnt_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic {LOW = 1'b0, HIGH = 1'b1} state_t;

    state_t           r_state, w_state_nxt;
    logic [7:0]       r_lo;
    logic [CW-1:0]    r_cnt, w_cnt_nxt;
    logic             w_lo_load, w_push, w_tmo;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr, r_rd_ptr;
    logic [AW:0]      r_fill;
    logic             w_pop, w_accept, w_ovf, w_drop;
    logic             r_ovf, r_und, r_tmo;
    logic [7:0]       r_drop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= LOW;
            r_cnt   <= '0;
            r_lo    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_lo_load) r_lo <= byte_i;
        end
    end

    // The timeout fires on the TIMEOUT-th idle edge after the low byte, so compare against TIMEOUT-1.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_lo_load   = 1'b0;
        w_push      = 1'b0;
        w_tmo       = 1'b0;
        if (resync_i) begin
            w_state_nxt = LOW;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                LOW: begin
                    if (byte_valid_i) begin
                        w_lo_load   = 1'b1;
                        w_cnt_nxt   = '0;
                        w_state_nxt = HIGH;
                    end
                end
                HIGH: begin
                    if (byte_valid_i) begin
                        w_push      = 1'b1;
                        w_state_nxt = LOW;
                    end else if (r_cnt == CW'(TIMEOUT - 1)) begin
                        w_tmo       = 1'b1;
                        w_cnt_nxt   = '0;
                        w_state_nxt = LOW;
                    end else begin
                        w_cnt_nxt = r_cnt + CW'(1);
                    end
                end
                default: w_state_nxt = LOW;
            endcase
        end
    end

    assign merge_finished_o = (r_fill != '0);
    assign w_pop    = start_i && merge_finished_o;
    assign w_accept = w_push && ((r_fill != (AW+1)'(DEPTH)) || w_pop);
    assign w_ovf    = w_push && !w_accept;
    assign w_drop   = w_ovf || w_tmo;

    always_ff @(posedge clk) begin
        if (w_accept) r_mem[r_wr_ptr] <= {byte_i, r_lo};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_fill   <= '0;
            r_ovf    <= 1'b0;
            r_und    <= 1'b0;
            r_tmo    <= 1'b0;
            r_drop   <= '0;
        end else begin
            if (w_accept) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)    r_rd_ptr <= r_rd_ptr + AW'(1);
            r_fill <= r_fill + (AW+1)'(w_accept) - (AW+1)'(w_pop);
            r_ovf  <= w_ovf;
            r_und  <= start_i && !merge_finished_o;
            r_tmo  <= w_tmo;
            if (w_drop && (r_drop != 8'hFF)) r_drop <= r_drop + 8'd1;
        end
    end

    assign data_o     = merge_finished_o ? r_mem[r_rd_ptr] : '0;
    assign fill_o     = r_fill;
    assign overflow_o = r_ovf;
    assign underrun_o = r_und;
    assign timeout_o  = r_tmo;
    assign drop_cnt_o = r_drop;
endmodule
